// File: rtl/conv_sched.sv
// Control sequencer for an N-sample / M-tap convolution datapath.
// Loads x and f memories, walks the MAC read schedule per output and presents each result on a valid/ready port.
module conv_sched #(
    parameter int N    = 8,
    parameter int M    = 4,
    parameter int LOGN = 3,
    parameter int LOGM = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            s_valid_x,
    output logic            s_ready_x,
    input  logic            s_valid_f,
    output logic            s_ready_f,
    output logic            wr_en_x,
    output logic [LOGN-1:0] addr_x,
    output logic            wr_en_f,
    output logic [LOGM-1:0] addr_f,
    output logic            en_acc,
    output logic            clr_acc,
    output logic            m_valid_y,
    input  logic            m_ready_y,
    output logic            m_last_y
);

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        MAC   = 2'd1,
        DRAIN = 2'd2,
        OUT   = 2'd3
    } state_t;

    localparam logic [LOGN:0] N_FULL = (LOGN+1)'(N);
    localparam logic [LOGM:0] M_FULL = (LOGM+1)'(M);
    localparam logic [LOGN:0] K_LAST = (LOGN+1)'(N - M);
    localparam logic [LOGM:0] J_LAST = (LOGM+1)'(M - 1);
    localparam logic [LOGN:0] ONE_N  = (LOGN+1)'(1);
    localparam logic [LOGM:0] ONE_M  = (LOGM+1)'(1);

    state_t          state_reg, state_next;
    logic [LOGN:0]   x_cnt_reg, x_cnt_next;
    logic [LOGM:0]   f_cnt_reg, f_cnt_next;
    logic [LOGN:0]   k_reg, k_next;
    logic [LOGM:0]   j_reg, j_next;
    logic            en_acc_reg, clr_acc_reg;

    // Read address is formed one bit wider so k+j can never wrap silently.
    logic [LOGN:0]   rd_addr_x;
    logic            rd_addr_unused;

    assign rd_addr_x      = k_reg + (LOGN+1)'(j_reg);
    assign rd_addr_unused = rd_addr_x[LOGN];

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= LOAD;
            x_cnt_reg   <= '0;
            f_cnt_reg   <= '0;
            k_reg       <= '0;
            j_reg       <= '0;
            en_acc_reg  <= 1'b0;
            clr_acc_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            x_cnt_reg   <= x_cnt_next;
            f_cnt_reg   <= f_cnt_next;
            k_reg       <= k_next;
            j_reg       <= j_next;
            // Memory read has one cycle of latency, so accumulate controls trail the read issue by one cycle.
            en_acc_reg  <= (state_reg == MAC);
            clr_acc_reg <= (state_reg == MAC) && (j_reg == '0);
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        x_cnt_next = x_cnt_reg;
        f_cnt_next = f_cnt_reg;
        k_next     = k_reg;
        j_next     = j_reg;
        unique case (state_reg)
            LOAD: begin
                if (wr_en_x) x_cnt_next = x_cnt_reg + ONE_N;
                if (wr_en_f) f_cnt_next = f_cnt_reg + ONE_M;
                if ((x_cnt_next == N_FULL) && (f_cnt_next == M_FULL)) begin
                    state_next = MAC;
                    j_next     = '0;
                end
            end
            MAC: begin
                if (j_reg == J_LAST) begin
                    state_next = DRAIN;
                end else begin
                    j_next = j_reg + ONE_M;
                end
            end
            DRAIN: begin
                state_next = OUT;
            end
            OUT: begin
                if (m_ready_y) begin
                    if (k_reg < K_LAST) begin
                        k_next     = k_reg + ONE_N;
                        j_next     = '0;
                        state_next = MAC;
                    end else begin
                        k_next     = '0;
                        j_next     = '0;
                        x_cnt_next = '0;
                        f_cnt_next = '0;
                        state_next = LOAD;
                    end
                end
            end
            default: state_next = LOAD;
        endcase
    end

    // Output logic
    always_comb begin
        s_ready_x = 1'b0;
        s_ready_f = 1'b0;
        wr_en_x   = 1'b0;
        wr_en_f   = 1'b0;
        addr_x    = rd_addr_x[LOGN-1:0];
        addr_f    = j_reg[LOGM-1:0];
        m_valid_y = 1'b0;
        m_last_y  = 1'b0;
        en_acc    = en_acc_reg;
        clr_acc   = clr_acc_reg;
        unique case (state_reg)
            LOAD: begin
                s_ready_x = (x_cnt_reg < N_FULL);
                s_ready_f = (f_cnt_reg < M_FULL);
                wr_en_x   = s_valid_x & s_ready_x;
                wr_en_f   = s_valid_f & s_ready_f;
                addr_x    = x_cnt_reg[LOGN-1:0];
                addr_f    = f_cnt_reg[LOGM-1:0];
            end
            OUT: begin
                m_valid_y = 1'b1;
                m_last_y  = (k_reg == K_LAST);
            end
            default: begin
            end
        endcase
    end

endmodule
